// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: 2-FF synchronised rx, mid-bit sampling, single holding register with
// per-character parity/framing/break status and a sticky overrun flag.
module uart_rx_oversampled #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       rx,
  input  logic [1:0] data_bits,
  input  logic       parity_en,
  input  logic       parity_even,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       parity_error,
  output logic       framing_error,
  output logic       break_detect,
  output logic       overrun_error,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  localparam logic [CNT_W-1:0] START_PT = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_PT   = CNT_W'(OVERSAMPLE - 1);

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [1:0]       cfg_bits;
  logic             cfg_pen;
  logic             cfg_peven;
  logic             par_bit;
  logic [7:0]       char_dat;
  logic             par_err;
  logic             brk;
  logic             start_pt;
  logic             bit_pt;

  // LSB-first shifting leaves an N-bit word in the top of shreg; right-justify it.
  assign char_dat = shreg >> (2'd3 - cfg_bits);
  assign par_err  = cfg_pen && (((^char_dat) ^ par_bit) != !cfg_peven);
  assign brk      = !rx_s && (char_dat == 8'h00) && (!cfg_pen || !par_bit);
  assign start_pt = sample_tick && (tick_cnt == START_PT);
  assign bit_pt   = sample_tick && (tick_cnt == BIT_PT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      cfg_bits      <= '0;
      cfg_pen       <= 1'b0;
      cfg_peven     <= 1'b0;
      par_bit       <= 1'b0;
      rx_data       <= '0;
      data_ready    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      break_detect  <= 1'b0;
      overrun_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;

      // A read empties the holder; a commit on the same clock overrides this below.
      if (rd_en) begin
        data_ready    <= 1'b0;
        parity_error  <= 1'b0;
        framing_error <= 1'b0;
        break_detect  <= 1'b0;
        overrun_error <= 1'b0;
      end

      if (sample_tick) tick_cnt <= tick_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state     <= START;
            busy      <= 1'b1;
            tick_cnt  <= '0;
            cfg_bits  <= data_bits;
            cfg_pen   <= parity_en;
            cfg_peven <= parity_even;
          end
        end
        START: begin
          if (start_pt) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (bit_pt) begin
            tick_cnt <= '0;
            shreg    <= {rx_s, shreg[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == {1'b1, cfg_bits}) state <= cfg_pen ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_pt) begin
            tick_cnt <= '0;
            par_bit  <= rx_s;
            state    <= STOP;
          end
        end
        STOP: begin
          if (bit_pt) begin
            tick_cnt <= '0;
            if (!data_ready || rd_en) begin
              rx_data       <= char_dat;
              parity_error  <= par_err;
              framing_error <= !rx_s;
              break_detect  <= brk;
              data_ready    <= 1'b1;
            end else begin
              overrun_error <= 1'b1;
            end
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tick_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: per-frame transaction model with exact commit/busy cycles,
// checked every clock, plus literal expectations for each scenario.
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_tick;
  logic       rx;
  logic [1:0] data_bits;
  logic       parity_en;
  logic       parity_even;
  logic       rd_en;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       parity_error;
  logic       framing_error;
  logic       break_detect;
  logic       overrun_error;
  logic       busy;

  uart_rx_oversampled #(.OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx(rx),
    .data_bits(data_bits), .parity_en(parity_en), .parity_even(parity_even),
    .rd_en(rd_en), .rx_data(rx_data), .data_ready(data_ready),
    .parity_error(parity_error), .framing_error(framing_error),
    .break_detect(break_detect), .overrun_error(overrun_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
  } commit_t;

  typedef struct {
    int s;
    int e;
  } span_t;

  commit_t    cq[$];
  span_t      bq[$];
  commit_t    m_c;
  int         cyc    = 0;
  int         n_vec  = 0;
  int         n_bad  = 0;
  logic [7:0] m_data = '0;
  logic       m_dr = 0, m_pe = 0, m_fe = 0, m_brk = 0, m_ovr = 0, m_busy = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Posedges are numbered by cyc; sample_tick is high on every posedge divisible by 4.
  initial begin
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      sample_tick = ((cyc + 1) % 4 == 0);
    end
  end

  // Model: apply the events scheduled for this posedge, then compare every output.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (!rst) begin
        m_data = '0; m_dr = 0; m_pe = 0; m_fe = 0; m_brk = 0; m_ovr = 0; m_busy = 0;
        if (bq.size() > 0 && bq[0].e == cyc) void'(bq.pop_front());
      end else begin
        if (cq.size() > 0 && cq[0].cyc == cyc) begin
          m_c = cq.pop_front();
          if (!m_dr || rd_en) begin
            m_data = m_c.d; m_pe = m_c.pe; m_fe = m_c.fe; m_brk = m_c.brk; m_dr = 1;
          end else begin
            m_ovr = 1;
          end
          if (rd_en) m_ovr = 0;
        end else if (rd_en) begin
          m_dr = 0; m_pe = 0; m_fe = 0; m_brk = 0; m_ovr = 0;
        end
        if (bq.size() > 0 && bq[0].s == cyc) m_busy = 1;
        if (bq.size() > 0 && bq[0].e == cyc) begin
          m_busy = 0;
          void'(bq.pop_front());
        end
      end
      chk("cycle_outputs",
          {2'b00, rx_data, data_ready, parity_error, framing_error, break_detect, overrun_error, busy},
          {2'b00, m_data, m_dr, m_pe, m_fe, m_brk, m_ovr, m_busy});
    end
  end

  task automatic align();
    do @(negedge clk); while ((cyc + 1) % 4 != 0);
  endtask

  // One frame starting at posedge k0; bit j covers posedges k0+64j .. k0+64j+63.
  task automatic frame(input logic [7:0] d, input logic [1:0] db, input logic pen,
                       input logic peven, input logic flip, input logic rdc, input int abort_at);
    int         n, nb, k0, ss;
    logic       line [0:10];
    logic [7:0] dm;
    logic       pb;
    commit_t    c;
    span_t      sp;
    n = 5 + db;
    dm = d & (8'hFF >> (8 - n));
    data_bits = db; parity_en = pen; parity_even = peven;
    align();
    k0 = cyc + 1;
    line[0] = 1'b0;
    for (int i = 0; i < n; i++) line[1 + i] = dm[i];
    pb = (^dm) ^ !peven ^ flip;
    nb = n + 2 + int'(pen);
    if (pen) line[n + 1] = pb;
    line[nb - 1] = 1'b1;
    ss = k0 + 32 + 64 * (nb - 1);
    sp.s = k0 + 2;
    if (abort_at < 0) begin
      c.cyc = ss; c.d = dm; c.fe = 0; c.brk = 0;
      c.pe = pen && ((((^dm) ^ pb) ? 1'b1 : 1'b0) != (peven ? 1'b0 : 1'b1));
      cq.push_back(c);
      sp.e = ss;
    end else begin
      sp.e = k0 + abort_at;
    end
    bq.push_back(sp);
    for (int t = 0; t < 64 * nb; t++) begin
      rx = line[t / 64];
      rd_en = rdc && (k0 + t == ss);
      if (t == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        return;
      end
      @(negedge clk);
    end
    rx = 1'b1;
    rd_en = 1'b0;
  endtask

  // Line low for clks cycles under 8N1; long lows commit a break and then wait for rx high.
  task automatic low_pulse(input int clks, input logic is_break);
    int      k0;
    commit_t c;
    span_t   sp;
    data_bits = 2'b11; parity_en = 1'b0; parity_even = 1'b0;
    align();
    k0 = cyc + 1;
    sp.s = k0 + 2;
    if (is_break) begin
      c.cyc = k0 + 608; c.d = 8'h00; c.pe = 0; c.fe = 1; c.brk = 1;
      cq.push_back(c);
      sp.e = k0 + clks + 2;
    end else begin
      sp.e = k0 + 32;
    end
    bq.push_back(sp);
    rx = 1'b0;
    repeat (clks) @(negedge clk);
    rx = 1'b1;
    repeat (80) @(negedge clk);
  endtask

  task automatic rd_pulse();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; rx = 1'b1; rd_en = 1'b0;
    data_bits = 2'b11; parity_en = 1'b0; parity_even = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {rx_data, data_ready, parity_error, framing_error, break_detect, overrun_error, busy}, 16'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    frame(8'hA5, 2'b11, 0, 0, 0, 0, -1);
    chk("a5_data", rx_data, 16'h00A5);
    chk("a5_model", m_data, 16'h00A5);
    chk("a5_status", {data_ready, parity_error, framing_error, break_detect, overrun_error, busy}, 16'b100000);
    rd_pulse();
    chk("a5_read", {rx_data, data_ready}, {8'hA5, 1'b0});

    frame(8'h35, 2'b10, 1, 1, 1, 0, -1);
    chk("7e1_data", rx_data, 16'h0035);
    chk("7e1_perr", {data_ready, parity_error}, 16'b11);
    rd_pulse();
    chk("7e1_read", {data_ready, parity_error}, 16'b00);

    low_pulse(12, 1'b0);
    chk("glitch_rdy", {data_ready, busy}, 16'b00);
    frame(8'h3C, 2'b11, 0, 0, 0, 0, -1);
    chk("3c_data", {rx_data, data_ready}, {8'h3C, 1'b1});
    rd_pulse();

    low_pulse(1280, 1'b1);
    chk("break_data", rx_data, 16'h0000);
    chk("break_status", {data_ready, framing_error, break_detect, overrun_error, busy}, 16'b11100);
    rd_pulse();

    frame(8'h11, 2'b11, 0, 0, 0, 0, -1);
    frame(8'h22, 2'b11, 0, 0, 0, 0, -1);
    chk("ovr_data", {rx_data, overrun_error}, {8'h11, 1'b1});
    frame(8'h33, 2'b11, 0, 0, 0, 1, -1);
    chk("rdcommit", {rx_data, data_ready, overrun_error}, {8'h33, 2'b10});
    rd_pulse();

    frame(8'h1F, 2'b00, 0, 0, 0, 0, 64 * 3 + 10);
    chk("abort_state", {rx_data, data_ready, parity_error, framing_error, break_detect, overrun_error, busy}, 16'h0);
    frame(8'h0A, 2'b00, 0, 0, 0, 0, -1);
    chk("5n1_data", {rx_data, data_ready}, {8'h0A, 1'b1});

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
